// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg : shared constants for the instruction-fetch unit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package if_pkg;

   localparam int PC_W_DEF = 9;
   localparam int PC_STEP  = 4;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_slot.sv
// ---------------------------------------------------------------------------
// fetch_slot : single-entry output slot (inst, pc, pc+4, valid) feeding IF/ID
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_slot #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic            i_consume,
   input  logic [31:0]     i_inst,
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_pc_plus,
   output logic            o_valid,
   output logic [31:0]     o_inst,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_plus
);

   logic            r_valid;
   logic [31:0]     r_inst;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pc_plus;

   // Clear outranks load; a refill in the consuming cycle keeps the slot full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_inst    <= '0;
         r_pc      <= '0;
         r_pc_plus <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid   <= 1'b1;
         r_inst    <= i_inst;
         r_pc      <= i_pc;
         r_pc_plus <= i_pc_plus;
      end else if (i_consume) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid   = r_valid;
   assign o_inst    = r_inst;
   assign o_pc      = r_pc;
   assign o_pc_plus = r_pc_plus;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit : PC register and request FSM with one outstanding imem read
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
   import if_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_F,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst_F,
   output logic [PC_W-1:0] PC_F,
   output logic [PC_W-1:0] PCPlusF_F,
   output logic            en_IF_ID,
   output logic            clr_IF_ID
);

   logic [1:0]      r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_plus;
   logic [PC_W-1:0] w_redirect_pc;
   logic            w_valid;
   logic            w_consume;
   logic            w_issue;
   logic            w_accept;
   logic            w_load;

   assign w_pc_plus     = r_pc + PC_W'(PC_STEP);
   assign w_redirect_pc = redirect_pc & ~PC_W'(3);

   assign w_consume = w_valid & ~stall_F & ~redirect;
   assign w_issue   = (r_state == S_REQ) & (~w_valid | w_consume) & ~redirect & ~rst;
   assign w_accept  = w_issue & imem_ready;
   assign w_load    = (r_state == S_WAIT) & imem_rvalid & ~redirect;

   assign imem_req  = w_issue;
   assign imem_addr = r_pc;
   assign en_IF_ID  = rst | ~stall_F | redirect;
   assign clr_IF_ID = rst | redirect | ~w_valid;

   // A response arriving with the redirect retires the outstanding read, so
   // DROP is only needed when that read is still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
      end else if (redirect) begin
         r_pc <= w_redirect_pc;
         if ((r_state != S_REQ) && !imem_rvalid) r_state <= S_DROP;
         else                                    r_state <= S_REQ;
      end else begin
         case (r_state)
            S_REQ:   if (w_accept) r_state <= S_WAIT;
            S_WAIT:  if (imem_rvalid) begin
                        r_pc    <= w_pc_plus;
                        r_state <= S_REQ;
                     end
            S_DROP:  if (imem_rvalid) r_state <= S_REQ;
            default: r_state <= S_REQ;
         endcase
      end
   end

   fetch_slot #(
      .PC_W (PC_W)
   ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_clear   (redirect),
      .i_consume (w_consume),
      .i_inst    (imem_rdata),
      .i_pc      (r_pc),
      .i_pc_plus (w_pc_plus),
      .o_valid   (w_valid),
      .o_inst    (inst_F),
      .o_pc      (PC_F),
      .o_pc_plus (PCPlusF_F)
   );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit : directed self-checking bench for if_fetch_unit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_F = 1'b0;
   logic        redirect = 1'b0;
   logic [8:0]  redirect_pc = '0;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] inst_F;
   logic [8:0]  PC_F;
   logic [8:0]  PCPlusF_F;
   logic        en_IF_ID;
   logic        clr_IF_ID;

   int total = 0;
   int bad   = 0;

   int         lat   = 1;
   logic       pend  = 1'b0;
   int         cnt   = 0;
   logic [8:0] paddr = '0;

   always #5 clk = ~clk;

   if_fetch_unit #(.PC_W(9), .RESET_PC(9'h000)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_F     (stall_F),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_F      (inst_F),
      .PC_F        (PC_F),
      .PCPlusF_F   (PCPlusF_F),
      .en_IF_ID    (en_IF_ID),
      .clr_IF_ID   (clr_IF_ID)
   );

   function automatic logic [31:0] mkdata(input logic [8:0] a);
      return {20'hC0DE0, 3'b000, a};
   endfunction

   // One clock; the memory model answers `lat` cycles after acceptance.
   task automatic step();
      logic       acc;
      logic [8:0] a;
      acc = imem_req & imem_ready;
      a   = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
         pend  = 1'b1;
         cnt   = lat;
         paddr = a;
      end
      if (pend) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mkdata(paddr);
            pend        = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_F = 1'b1;
      step(); step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      total++; if (en_IF_ID !== 1'b1) begin bad++; $display("FAIL rst_en got=%b exp=1", en_IF_ID); end
      total++; if (clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rst_clr got=%b exp=1", clr_IF_ID); end
      total++; if (inst_F !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst_F); end
      total++; if (PC_F !== 9'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", PC_F); end
      total++; if (PCPlusF_F !== 9'h0) begin bad++; $display("FAIL rst_pcp got=%h exp=0", PCPlusF_F); end
      stall_F = 1'b0;
   endtask

   task automatic test_fetch_seq();
      rst = 1'b0; #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin bad++; $display("FAIL seq_a0 got=%b/%h exp=1/000", imem_req, imem_addr); end
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_wait got=%b exp=0", imem_req); end
      step();
      total++; if (PC_F !== 9'h000 || PCPlusF_F !== 9'h004) begin bad++; $display("FAIL seq_slot0 got=%h/%h exp=000/004", PC_F, PCPlusF_F); end
      total++; if (inst_F !== 32'hC0DE0000) begin bad++; $display("FAIL seq_inst0 got=%h exp=c0de0000", inst_F); end
      total++; if (clr_IF_ID !== 1'b0) begin bad++; $display("FAIL seq_clr got=%b exp=0", clr_IF_ID); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h004) begin bad++; $display("FAIL seq_a4 got=%b/%h exp=1/004", imem_req, imem_addr); end
      step(); step();
      total++; if (PC_F !== 9'h004) begin bad++; $display("FAIL seq_slot1 got=%h exp=004", PC_F); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h008) begin bad++; $display("FAIL seq_a8 got=%b/%h exp=1/008", imem_req, imem_addr); end
   endtask

   task automatic test_stall();
      stall_F = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (en_IF_ID !== 1'b0) begin bad++; $display("FAIL stall_en[%0d] got=%b exp=0", i, en_IF_ID); end
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
         total++; if (PC_F !== 9'h004 || inst_F !== 32'hC0DE0004) begin bad++; $display("FAIL stall_slot[%0d] got=%h/%h exp=004/c0de0004", i, PC_F, inst_F); end
         step();
      end
      stall_F = 1'b0; #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h008 || en_IF_ID !== 1'b1) begin bad++; $display("FAIL stall_rel got=%b/%h/%b exp=1/008/1", imem_req, imem_addr, en_IF_ID); end
   endtask

   task automatic test_redirect_wait();
      lat = 2;
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_wait got=%b exp=0", imem_req); end
      redirect = 1'b1; redirect_pc = 9'h0A3; #1;
      total++; if (clr_IF_ID !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rdw_cyc got=%b/%b exp=1/0", clr_IF_ID, imem_req); end
      step();
      redirect = 1'b0; #1;
      total++; if (imem_req !== 1'b0 || clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rdw_drop got=%b/%b exp=0/1", imem_req, clr_IF_ID); end
      step();
      total++; if (clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rdw_discard got=%b exp=1", clr_IF_ID); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h0A0) begin bad++; $display("FAIL rdw_addr got=%b/%h exp=1/0a0", imem_req, imem_addr); end
      lat = 1;
      step(); step();
      total++; if (PC_F !== 9'h0A0 || PCPlusF_F !== 9'h0A4 || inst_F !== 32'hC0DE00A0) begin bad++; $display("FAIL rdw_slot got=%h/%h/%h exp=0a0/0a4/c0de00a0", PC_F, PCPlusF_F, inst_F); end
   endtask

   task automatic test_redirect_stall_rvalid();
      step();
      total++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rsr_setup got=%b/%b exp=1/0", imem_rvalid, imem_req); end
      redirect = 1'b1; stall_F = 1'b1; redirect_pc = 9'h15E; #1;
      total++; if (en_IF_ID !== 1'b1 || clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rsr_ctl got=%b/%b exp=1/1", en_IF_ID, clr_IF_ID); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rsr_req got=%b exp=0", imem_req); end
      step();
      redirect = 1'b0; stall_F = 1'b0; #1;
      total++; if (clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rsr_discard got=%b exp=1", clr_IF_ID); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h15C) begin bad++; $display("FAIL rsr_pc got=%b/%h exp=1/15c", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 9'h1FF; #1;
      step();
      redirect = 1'b0; #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h1FC) begin bad++; $display("FAIL wrap_a got=%b/%h exp=1/1fc", imem_req, imem_addr); end
      step(); step();
      total++; if (PC_F !== 9'h1FC || PCPlusF_F !== 9'h000) begin bad++; $display("FAIL wrap_slot got=%h/%h exp=1fc/000", PC_F, PCPlusF_F); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/000", imem_req, imem_addr); end
   endtask

   task automatic test_reset_mid_wait();
      lat = 3;
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmw_wait got=%b exp=0", imem_req); end
      rst = 1'b1; #1;
      total++; if (imem_req !== 1'b0 || clr_IF_ID !== 1'b1 || en_IF_ID !== 1'b1) begin bad++; $display("FAIL rmw_rst got=%b/%b/%b exp=0/1/1", imem_req, clr_IF_ID, en_IF_ID); end
      total++; if (PC_F !== 9'h000 || inst_F !== 32'h0) begin bad++; $display("FAIL rmw_slot got=%h/%h exp=000/0", PC_F, inst_F); end
      step();
      rst = 1'b0; imem_ready = 1'b0; #1;
      step();
      total++; if (imem_rvalid !== 1'b1) begin bad++; $display("FAIL rmw_late got=%b exp=1", imem_rvalid); end
      step();
      total++; if (clr_IF_ID !== 1'b1) begin bad++; $display("FAIL rmw_ignore got=%b exp=1", clr_IF_ID); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin bad++; $display("FAIL rmw_addr got=%b/%h exp=1/000", imem_req, imem_addr); end
      imem_ready = 1'b1; lat = 1; #1;
      step(); step();
      total++; if (PC_F !== 9'h000 || PCPlusF_F !== 9'h004 || inst_F !== 32'hC0DE0000) begin bad++; $display("FAIL rmw_fetch got=%h/%h/%h exp=000/004/c0de0000", PC_F, PCPlusF_F, inst_F); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch_seq();
      test_stall();
      test_redirect_wait();
      test_redirect_stall_rvalid();
      test_wrap();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, giving the byte-address PC width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address (word aligned).
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port stall_F, input, 1, hazard stall; the instruction slot is held and not consumed.
REQ-006 The block SHALL have port redirect, input, 1, taken branch or jump resolved downstream.
REQ-007 The block SHALL have port redirect_pc, input, PC_W, the new fetch address.
REQ-008 The block SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-009 The block SHALL have port imem_addr, output, PC_W, the request address.
REQ-010 The block SHALL have port imem_ready, input, 1, memory accepts the request this cycle.
REQ-011 The block SHALL have port imem_rvalid, input, 1, read data valid, at least 1 cycle after acceptance.
REQ-012 The block SHALL have port imem_rdata, input, 32, the instruction word.
REQ-013 The block SHALL have ports inst_F (output, 32), PC_F (output, PC_W) and PCPlusF_F (output, PC_W): the slot contents toward the IF/ID register.
REQ-014 The block SHALL have port en_IF_ID, output, 1, the IF/ID enable.
REQ-015 The block SHALL have port clr_IF_ID, output, 1, the IF/ID clear (bubble).

Function
REQ-016 The block SHALL keep a fetch PC register pc_q and a single-entry output slot (inst, pc, pc+4, valid).
REQ-017 The FSM SHALL have states REQ, WAIT and DROP, with at most one outstanding memory request.
REQ-018 In REQ: imem_req=1 and imem_addr=pc_q only while the slot is empty or is consumed this cycle; on imem_req&imem_ready the FSM goes to WAIT.
REQ-019 In WAIT with imem_rvalid: slot <= {imem_rdata, pc_q, pc_q+4}, valid=1; pc_q <= pc_q+4; the FSM goes to REQ.
REQ-020 In DROP with imem_rvalid: the data is discarded, the slot is unchanged and the FSM goes to REQ.
REQ-021 The slot SHALL be consumed when valid & !stall_F & !redirect; a consumed slot is emptied unless refilled the same cycle.
REQ-022 The block SHALL drive en_IF_ID = !stall_F | redirect, combinationally.
REQ-023 The block SHALL drive clr_IF_ID = redirect | !valid, combinationally.
REQ-024 On redirect: pc_q <= {redirect_pc[PC_W-1:2], 2'b00}; the slot is invalidated; from WAIT the FSM goes to DROP, otherwise to REQ; a request offered in the same cycle is withdrawn (imem_req=0).
REQ-025 Redirect SHALL have priority over stall_F and over imem_rvalid arriving in the same cycle, which is treated as stale.
REQ-026 A redirect while in DROP SHALL update pc_q and keep the FSM in DROP.
REQ-027 PC arithmetic SHALL be modulo 2^PC_W, so pc+4 wraps silently (the maximum word address wraps to 0).
REQ-028 An imem_rvalid received in REQ SHALL be ignored.
REQ-029 Best-case throughput SHALL be one instruction per 2 cycles with zero-wait memory; the first slot becomes valid no earlier than cycle 2 after reset release.

Reset
REQ-030 rst SHALL asynchronously set pc_q=RESET_PC, slot valid=0, inst_F=0, PC_F=0, PCPlusF_F=0 and FSM=REQ.
REQ-031 While rst is high, outputs SHALL be imem_req=0, en_IF_ID=1 and clr_IF_ID=1.
REQ-032 Reset SHALL abort any in-flight request, and a late imem_rvalid SHALL be ignored because the FSM is in REQ.

Structure
REQ-033 Shared package if_pkg SHALL hold the state encoding (REQ=0, WAIT=1, DROP=2), the PC_W default and the constant PC_STEP=4.
REQ-034 The output slot SHALL be sub-module fetch_slot (load, clear, hold); the FSM and PC logic stay in the top module.

Verification
REQ-035 Reset release with imem_ready=1 and rvalid 1 cycle after acceptance -> imem_addr sequence 0x000, 0x004, 0x008; PC_F/PCPlusF_F = 0x000/0x004 when the first slot is valid.
REQ-036 stall_F held 3 cycles with the slot valid -> en_IF_ID=0, the slot is stable and no new imem_req is issued once the slot is full.
REQ-037 redirect with redirect_pc=0x0A3 in WAIT -> the next rvalid is dropped, the next imem_addr is 0x0A0 and clr_IF_ID=1 in the redirect cycle.
REQ-038 pc_q=0x1FC and fetch completes -> PCPlusF_F=0x000 and the next imem_addr is 0x000.
REQ-039 redirect and stall_F together with imem_rvalid in the same cycle -> en_IF_ID=1, clr_IF_ID=1, the data is discarded and pc_q takes redirect_pc.
REQ-040 rst asserted mid-WAIT, then a late rvalid -> the slot stays invalid and the first post-reset imem_addr is RESET_PC.
